// File: rtl/note_led_driver_if.sv
// Note-code request and LED response bundle between the music sequencer and the LED driver.
interface note_led_driver_if #(
  parameter int NOTES_PER_OCT = 7,
  parameter int NUM_OCT       = 3,
  parameter int CODE_W        = 5
);
  logic [CODE_W-1:0]        music;
  logic [NOTES_PER_OCT-1:0] led;
  logic [NUM_OCT-1:0]       range;
  logic                     note_on;
  logic                     err;

  modport master (output music, input led, range, note_on, err);
  modport slave  (input music, output led, range, note_on, err);
endinterface

// File: rtl/note_led_driver.sv
// Note code -> one-hot note/octave LEDs with post-note hold, retrigger strobe and error blink.
// Optional LED_HOLD_DIM_EN: 25% duty after-glow on the note LED while holding.
module note_led_driver #(
  parameter int NOTES_PER_OCT = 7,
  parameter int NUM_OCT       = 3,
  parameter int CODE_W        = 5,
  parameter int HOLD_CYCLES   = 5000000,
  parameter int BLINK_CYCLES  = 25000000
) (
  input  logic clk,
  input  logic rst,
  note_led_driver_if.slave bus
);
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BCW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HCW-1:0]    HOLD_LOAD  = (HOLD_CYCLES > 0) ? HCW'(HOLD_CYCLES - 1) : '0;
  localparam logic [BCW-1:0]    BLINK_LAST = BCW'(BLINK_CYCLES - 1);
  localparam logic [CODE_W-1:0] MAX_CODE   = CODE_W'(NOTES_PER_OCT * NUM_OCT);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_HOLD, S_ERR} state_t;

  state_t                   r_state, w_state_nxt;
  logic [CODE_W-1:0]        r_lat, w_lat_nxt;
  logic [HCW-1:0]           r_hold_cnt, w_hold_nxt;
  logic [BCW-1:0]           r_blink_cnt, w_blink_nxt;
  logic                     r_blink_on, w_blink_on_nxt;
  logic [NOTES_PER_OCT-1:0] r_led, w_led_nxt;
  logic [NUM_OCT-1:0]       r_range, w_range_nxt;
  logic                     r_note_on, w_note_on_nxt;
  logic                     r_err, w_err_nxt;
  logic                     w_valid, w_invalid, w_dim_mask;

  // Compare chain over every valid code; lowest octave lands on the range MSB.
  function automatic logic [NOTES_PER_OCT-1:0] dec_led(input logic [CODE_W-1:0] c);
    dec_led = '0;
    for (int o = 0; o < NUM_OCT; o++)
      for (int n = 0; n < NOTES_PER_OCT; n++)
        if (c == CODE_W'(o * NOTES_PER_OCT + n + 1)) dec_led[n] = 1'b1;
  endfunction

  function automatic logic [NUM_OCT-1:0] dec_range(input logic [CODE_W-1:0] c);
    dec_range = '0;
    for (int o = 0; o < NUM_OCT; o++)
      for (int n = 0; n < NOTES_PER_OCT; n++)
        if (c == CODE_W'(o * NOTES_PER_OCT + n + 1)) dec_range[NUM_OCT-1-o] = 1'b1;
  endfunction

  assign w_valid   = (bus.music != '0) && (bus.music <= MAX_CODE);
  assign w_invalid = (bus.music > MAX_CODE);

`ifdef LED_HOLD_DIM_EN
  logic [1:0] r_dim_cnt, w_dim_nxt;
  assign w_dim_nxt  = r_dim_cnt + 2'd1;
  // Mask on the value the counter holds while the registered led is visible.
  assign w_dim_mask = (w_dim_nxt == 2'd0);
  always_ff @(posedge clk)
    if (rst) r_dim_cnt <= 2'd0;
    else     r_dim_cnt <= w_dim_nxt;
`else
  assign w_dim_mask = 1'b1;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_lat_nxt      = r_lat;
    w_hold_nxt     = r_hold_cnt;
    w_blink_nxt    = r_blink_cnt;
    w_blink_on_nxt = r_blink_on;
    w_note_on_nxt  = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_valid) begin
          w_lat_nxt = bus.music; w_state_nxt = S_SHOW; w_note_on_nxt = 1'b1;
        end else if (w_invalid) begin
          w_state_nxt = S_ERR; w_blink_nxt = '0; w_blink_on_nxt = 1'b1;
        end
      S_SHOW:
        if (bus.music == r_lat) begin
          w_state_nxt = S_SHOW;
        end else if (w_valid) begin
          w_lat_nxt = bus.music; w_note_on_nxt = 1'b1;
        end else if (w_invalid) begin
          w_state_nxt = S_ERR; w_blink_nxt = '0; w_blink_on_nxt = 1'b1;
        end else if (HOLD_CYCLES > 0) begin
          w_state_nxt = S_HOLD; w_hold_nxt = HOLD_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      S_HOLD:
        if (w_valid) begin
          w_lat_nxt = bus.music; w_state_nxt = S_SHOW; w_note_on_nxt = 1'b1;
        end else if (w_invalid) begin
          w_state_nxt = S_ERR; w_blink_nxt = '0; w_blink_on_nxt = 1'b1;
        end else if (r_hold_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_nxt = r_hold_cnt - HCW'(1);
        end
      S_ERR:
        if (w_valid) begin
          w_lat_nxt = bus.music; w_state_nxt = S_SHOW; w_note_on_nxt = 1'b1;
        end else if (!w_invalid) begin
          w_state_nxt = S_IDLE;
        end else if (r_blink_cnt == BLINK_LAST) begin
          w_blink_nxt = '0; w_blink_on_nxt = ~r_blink_on;
        end else begin
          w_blink_nxt = r_blink_cnt + BCW'(1);
        end
      default: w_state_nxt = S_IDLE;
    endcase

    w_led_nxt   = '0;
    w_range_nxt = '0;
    w_err_nxt   = 1'b0;
    case (w_state_nxt)
      S_SHOW: begin
        w_led_nxt = dec_led(w_lat_nxt); w_range_nxt = dec_range(w_lat_nxt);
      end
      S_HOLD: begin
        w_led_nxt = dec_led(w_lat_nxt) & {NOTES_PER_OCT{w_dim_mask}};
        w_range_nxt = dec_range(w_lat_nxt);
      end
      S_ERR: begin
        w_led_nxt = {NOTES_PER_OCT{w_blink_on_nxt}}; w_range_nxt = '1; w_err_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lat       <= '0;
      r_hold_cnt  <= '0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b0;
      r_led       <= '0;
      r_range     <= '0;
      r_note_on   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lat       <= w_lat_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_blink_cnt <= w_blink_nxt;
      r_blink_on  <= w_blink_on_nxt;
      r_led       <= w_led_nxt;
      r_range     <= w_range_nxt;
      r_note_on   <= w_note_on_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign bus.led     = r_led;
  assign bus.range   = r_range;
  assign bus.note_on = r_note_on;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_note_led_driver.sv
// Directed bench for note_led_driver with HOLD_CYCLES=4, BLINK_CYCLES=3.
module tb_note_led_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  note_led_driver_if #(.NOTES_PER_OCT(7), .NUM_OCT(3), .CODE_W(5)) u_if ();

  note_led_driver #(
    .NOTES_PER_OCT(7), .NUM_OCT(3), .CODE_W(5), .HOLD_CYCLES(4), .BLINK_CYCLES(3)
  ) dut (.clk(clk), .rst(rst), .bus(u_if.slave));

  always #5 clk = ~clk;

  // {led, range, note_on, err}
  function automatic logic [11:0] obs();
    return {u_if.led, u_if.range, u_if.note_on, u_if.err};
  endfunction

  // Drive one code, clock once, then settle past the edge before sampling.
  task automatic step(input logic [4:0] code, input logic r);
    @(negedge clk);
    u_if.music = code;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    for (int i = 0; i < 2; i++) begin
      step(5'd9, 1'b1);
      e = {7'b0000000, 3'b000, 1'b0, 1'b0};
      total++;
      if (obs() !== e) begin bad++; $display("FAIL reset[%0d] got=%b want=%b", i, obs(), e); end
    end
    step(5'd9, 1'b0);
    e = {7'b0000010, 3'b010, 1'b1, 1'b0};
    total++;
    if (obs() !== e) begin bad++; $display("FAIL reset_release got=%b want=%b", obs(), e); end
    step(5'd9, 1'b0);
    e = {7'b0000010, 3'b010, 1'b0, 1'b0};
    total++;
    if (obs() !== e) begin bad++; $display("FAIL same_code got=%b want=%b", obs(), e); end
  endtask

  task automatic test_octave_sweep();
    logic [4:0]  codes [6] = '{5'd1, 5'd7, 5'd8, 5'd14, 5'd15, 5'd21};
    logic [6:0]  leds  [6] = '{7'b0000001, 7'b1000000, 7'b0000001, 7'b1000000, 7'b0000001, 7'b1000000};
    logic [2:0]  rngs  [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
    logic [11:0] e;
    for (int i = 0; i < 6; i++) begin
      step(codes[i], 1'b0);
      e = {leds[i], rngs[i], 1'b1, 1'b0};
      total++;
      if (obs() !== e) begin bad++; $display("FAIL sweep code=%0d got=%b want=%b", codes[i], obs(), e); end
    end
  endtask

  task automatic test_hold();
    logic [11:0] e;
    step(5'd5, 1'b0);
    e = {7'b0010000, 3'b100, 1'b1, 1'b0};
    total++;
    if (obs() !== e) begin bad++; $display("FAIL hold_latch got=%b want=%b", obs(), e); end
    for (int i = 1; i <= 4; i++) begin
      step(5'd0, 1'b0);
      total++;
`ifdef LED_HOLD_DIM_EN
      if (u_if.range !== 3'b100 || u_if.note_on !== 1'b0 || (u_if.led & ~7'b0010000) !== 7'b0) begin
`else
      if (obs() !== {7'b0010000, 3'b100, 1'b0, 1'b0}) begin
`endif
        bad++; $display("FAIL hold_cycle%0d got=%b want=%b", i, obs(), {7'b0010000, 3'b100, 1'b0, 1'b0});
      end
    end
    step(5'd0, 1'b0);
    e = 12'b0;
    total++;
    if (obs() !== e) begin bad++; $display("FAIL hold_expire got=%b want=%b", obs(), e); end
  endtask

  task automatic test_retrigger();
    logic [11:0] e;
    step(5'd5, 1'b0);
    step(5'd0, 1'b0);
    step(5'd0, 1'b0);
    step(5'd5, 1'b0);
    e = {7'b0010000, 3'b100, 1'b1, 1'b0};
    total++;
    if (obs() !== e) begin bad++; $display("FAIL retrigger got=%b want=%b", obs(), e); end
    for (int i = 0; i < 6; i++) step(5'd5, 1'b0);
    e = {7'b0010000, 3'b100, 1'b0, 1'b0};
    total++;
    if (obs() !== e) begin bad++; $display("FAIL retrigger_show got=%b want=%b", obs(), e); end
  endtask

  task automatic test_error_blink();
    logic [11:0] e;
    for (int i = 0; i < 9; i++) begin
      step(5'd30, 1'b0);
      e = {((i / 3) == 1) ? 7'b0000000 : 7'b1111111, 3'b111, 1'b0, 1'b1};
      total++;
      if (obs() !== e) begin bad++; $display("FAIL blink[%0d] got=%b want=%b", i, obs(), e); end
    end
    step(5'd0, 1'b0);
    e = 12'b0;
    total++;
    if (obs() !== e) begin bad++; $display("FAIL err_exit got=%b want=%b", obs(), e); end
  endtask

  task automatic test_err_to_note();
    logic [11:0] e;
    step(5'd30, 1'b0);
    step(5'd16, 1'b0);
    e = {7'b0000010, 3'b001, 1'b1, 1'b0};
    total++;
    if (obs() !== e) begin bad++; $display("FAIL err_to_note got=%b want=%b", obs(), e); end
  endtask

  task automatic test_reset_mid_hold();
    logic [11:0] e;
    step(5'd0, 1'b0);
    e = {7'b0000010, 3'b001, 1'b0, 1'b0};
    total++;
`ifdef LED_HOLD_DIM_EN
    if (u_if.range !== 3'b001) begin
`else
    if (obs() !== e) begin
`endif
      bad++; $display("FAIL rst_hold_entry got=%b want=%b", obs(), e);
    end
    step(5'd0, 1'b1);
    e = 12'b0;
    total++;
    if (obs() !== e) begin bad++; $display("FAIL rst_mid_hold got=%b want=%b", obs(), e); end
    for (int i = 0; i < 5; i++) begin
      step(5'd0, 1'b0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL no_residual[%0d] got=%b want=%b", i, obs(), e); end
    end
  endtask

  initial begin
    u_if.music = '0;
    test_reset();
    test_octave_sweep();
    test_hold();
    test_retrigger();
    test_error_blink();
    test_err_to_note();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
